// File: rtl/latch_mem_wr_sched.sv
// Write-port scheduler for a latch-based register memory: grants up to two
// requesters per cycle onto ports A/B and can run a zeroing sweep of the array.
module latch_mem_wr_sched #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned NUM_WORDS  = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 128
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear_i,
    output logic                           busy_o,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_i,
    output logic [ADDR_WIDTH-1:0]          waddr_a_o,
    output logic [DATA_WIDTH-1:0]          wdata_a_o,
    output logic                           we_a_o,
    output logic [ADDR_WIDTH-1:0]          waddr_b_o,
    output logic [DATA_WIDTH-1:0]          wdata_b_o,
    output logic                           we_b_o,
    output logic                           drop_o
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = ADDR_WIDTH + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_t;

    logic [0:0]            state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [PW-1:0]         rr_ptr, rr_nxt;
    logic                  busy, busy_nxt;
    logic                  drop, drop_nxt;
    logic                  we_a, we_a_nxt;
    logic                  we_b, we_b_nxt;
    wr_t                   port_a, port_a_nxt;
    wr_t                   port_b, port_b_nxt;

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    grant;
    logic [PW-1:0]         idx;
    logic [PW-1:0]         a_idx, b_idx, last_idx;
    logic                  a_found, b_found;
    logic                  a_ok, b_ok;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_arr[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && (32'(a) < NUM_WORDS);
    endfunction

    // Round-robin pick of up to two requesters; B skips any address equal to A's.
    always_comb begin
        grant   = '0;
        idx     = '0;
        a_idx   = '0;
        b_idx   = '0;
        a_found = 1'b0;
        b_found = 1'b0;
        if (state == ST_IDLE) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = PW'((32'(rr_ptr) + k) % NUM_REQ);
                if (req_valid_i[idx]) begin
                    if (!a_found) begin
                        a_found    = 1'b1;
                        a_idx      = idx;
                        grant[idx] = 1'b1;
                    end else if (!b_found && (addr_arr[idx] != addr_arr[a_idx])) begin
                        b_found    = 1'b1;
                        b_idx      = idx;
                        grant[idx] = 1'b1;
                    end
                end
            end
        end
    end

    assign req_ready_o = rst ? '0 : grant;
    assign a_ok        = a_found && addr_ok(addr_arr[a_idx]);
    assign b_ok        = b_found && addr_ok(addr_arr[b_idx]);
    assign last_idx    = b_found ? b_idx : a_idx;

    // Next-state and next-output logic for both IDLE scheduling and the sweep.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rr_nxt     = rr_ptr;
        busy_nxt   = 1'b0;
        drop_nxt   = 1'b0;
        we_a_nxt   = 1'b0;
        we_b_nxt   = 1'b0;
        port_a_nxt = port_a;
        port_b_nxt = port_b;
        case (state)
            ST_IDLE: begin
                if (a_found) begin
                    rr_nxt = PW'((32'(last_idx) + 32'd1) % NUM_REQ);
                end
                drop_nxt = (a_found && !a_ok) || (b_found && !b_ok);
                if (a_ok) begin
                    we_a_nxt        = 1'b1;
                    port_a_nxt.addr = addr_arr[a_idx];
                    port_a_nxt.data = data_arr[a_idx];
                    if (b_ok) begin
                        we_b_nxt        = 1'b1;
                        port_b_nxt.addr = addr_arr[b_idx];
                        port_b_nxt.data = data_arr[b_idx];
                    end
                end else if (b_ok) begin
                    // A lone surviving write always goes out on port A.
                    we_a_nxt        = 1'b1;
                    port_a_nxt.addr = addr_arr[b_idx];
                    port_a_nxt.data = data_arr[b_idx];
                end
                if (clear_i) begin
                    state_nxt = ST_CLEAR;
                    busy_nxt  = 1'b1;
                end
            end
            ST_CLEAR: begin
                busy_nxt        = 1'b1;
                we_a_nxt        = 1'b1;
                port_a_nxt.addr = ADDR_WIDTH'(cnt);
                port_a_nxt.data = '0;
                if (32'(cnt) + 32'd1 < NUM_WORDS) begin
                    we_b_nxt        = 1'b1;
                    port_b_nxt.addr = ADDR_WIDTH'(cnt + CW'(1));
                    port_b_nxt.data = '0;
                end
                if (32'(cnt) + 32'd2 >= NUM_WORDS) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = CW'(1);
                end else begin
                    cnt_nxt = cnt + CW'(2);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = CW'(1);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= CW'(1);
            rr_ptr <= '0;
            busy   <= 1'b0;
            drop   <= 1'b0;
            we_a   <= 1'b0;
            we_b   <= 1'b0;
            port_a <= '0;
            port_b <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rr_ptr <= rr_nxt;
            busy   <= busy_nxt;
            drop   <= drop_nxt;
            we_a   <= we_a_nxt;
            we_b   <= we_b_nxt;
            port_a <= port_a_nxt;
            port_b <= port_b_nxt;
        end
    end

    assign busy_o    = busy;
    assign drop_o    = drop;
    assign we_a_o    = we_a;
    assign we_b_o    = we_b;
    assign waddr_a_o = port_a.addr;
    assign wdata_a_o = port_a.data;
    assign waddr_b_o = port_b.addr;
    assign wdata_b_o = port_b.data;

endmodule

// File: tb/tb_latch_mem_wr_sched.sv
// Directed bench for latch_mem_wr_sched: arbitration, drops, sweep and reset.
module tb_latch_mem_wr_sched;

    localparam int NR = 4;
    localparam int NW = 32;
    localparam int AW = 6;
    localparam int DW = 32;

    logic              clk;
    logic              rst;
    logic              clear;
    logic              busy;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [AW-1:0]     waddr_a, waddr_b;
    logic [DW-1:0]     wdata_a, wdata_b;
    logic              we_a, we_b;
    logic              drop;

    int n_checks = 0;
    int n_err    = 0;
    int gcount [NR];

    latch_mem_wr_sched #(
        .NUM_REQ(NR), .NUM_WORDS(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .clear_i(clear), .busy_o(busy),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_data_i(req_data),
        .waddr_a_o(waddr_a), .wdata_a_o(wdata_a), .we_a_o(we_a),
        .waddr_b_o(waddr_b), .wdata_b_o(wdata_b), .we_b_o(we_b),
        .drop_o(drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic ea, input int aa, input int da,
                          input logic eb, input int ab, input int db);
        chk({tag, ".we_a"},    128'(we_a),    128'(ea));
        chk({tag, ".waddr_a"}, 128'(waddr_a), 128'(aa));
        chk({tag, ".wdata_a"}, 128'(wdata_a), 128'(da));
        chk({tag, ".we_b"},    128'(we_b),    128'(eb));
        chk({tag, ".waddr_b"}, 128'(waddr_b), 128'(ab));
        chk({tag, ".wdata_b"}, 128'(wdata_b), 128'(db));
    endtask

    task automatic set_req(input int r, input logic v, input int a, input int d);
        req_valid[r]        = v;
        req_addr[r*AW +: AW] = AW'(a);
        req_data[r*DW +: DW] = DW'(d);
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        for (int r = 0; r < NR; r++) gcount[r] = 0;

        // Reset: no readies while rst is high, outputs cleared.
        step();
        for (int r = 0; r < NR; r++) set_req(r, 1'b1, 10 + r, 'h50 + r);
        #1;
        chk("rst_ready", 128'(req_ready), 128'(0));
        step();
        chk_wr("rst", 1'b0, 0, 0, 1'b0, 0, 0);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_drop", 128'(drop), 128'(0));
        req_valid = '0;
        rst       = 1'b0;
        step();

        // Requesters 0,1,2 -> grants 0 on A, 1 on B.
        set_req(0, 1'b1, 3, 'hA0);
        set_req(1, 1'b1, 4, 'hA1);
        set_req(2, 1'b1, 5, 'hA2);
        #1;
        chk("rr0_ready", 128'(req_ready), 128'(4'b0011));
        step();
        chk_wr("rr0_wr", 1'b1, 3, 'hA0, 1'b1, 4, 'hA1);
        chk("rr0_drop", 128'(drop), 128'(0));
        // rr_ptr now 2: requester 2 on A, wrap to 0 on B.
        #1;
        chk("rr2_ready", 128'(req_ready), 128'(4'b0101));
        step();
        chk_wr("rr2_wr", 1'b1, 5, 'hA2, 1'b1, 3, 'hA0);
        req_valid = '0;
        step();
        chk_wr("idle_hold", 1'b0, 5, 'hA2, 1'b0, 3, 'hA0);

        // Single requester 3 moves rr_ptr back to 0.
        set_req(3, 1'b1, 9, 'h09);
        #1;
        chk("r3_ready", 128'(req_ready), 128'(4'b1000));
        step();
        req_valid = '0;
        chk_wr("r3_wr", 1'b1, 9, 'h09, 1'b0, 3, 'hA0);

        // Same-address conflict: only requester 0 now, requester 1 next cycle.
        set_req(0, 1'b1, 7, 'hB0);
        set_req(1, 1'b1, 7, 'hB1);
        #1;
        chk("conf_ready0", 128'(req_ready), 128'(4'b0001));
        step();
        set_req(0, 1'b0, 7, 'hB0);
        chk_wr("conf_wr0", 1'b1, 7, 'hB0, 1'b0, 3, 'hA0);
        #1;
        chk("conf_ready1", 128'(req_ready), 128'(4'b0010));
        step();
        req_valid = '0;
        chk_wr("conf_wr1", 1'b1, 7, 'hB1, 1'b0, 3, 'hA0);

        // Address 0 and out-of-range address are acknowledged then dropped.
        set_req(2, 1'b1, 0, 'hCC);
        #1;
        chk("drop0_ready", 128'(req_ready), 128'(4'b0100));
        step();
        chk_wr("drop0_wr", 1'b0, 7, 'hB1, 1'b0, 3, 'hA0);
        chk("drop0_drop", 128'(drop), 128'(1));
        set_req(2, 1'b1, 40, 'hCD);
        #1;
        chk("drop40_ready", 128'(req_ready), 128'(4'b0100));
        step();
        req_valid = '0;
        chk_wr("drop40_wr", 1'b0, 7, 'hB1, 1'b0, 3, 'hA0);
        chk("drop40_drop", 128'(drop), 128'(1));
        step();
        chk("drop_clr", 128'(drop), 128'(0));

        // rr_ptr=3: requester 3 dropped on A, requester 0 moves from B to A.
        set_req(3, 1'b1, 0, 'hC3);
        set_req(0, 1'b1, 12, 'hC0);
        #1;
        chk("mv_ready", 128'(req_ready), 128'(4'b1001));
        step();
        req_valid = '0;
        chk_wr("mv_wr", 1'b1, 12, 'hC0, 1'b0, 3, 'hA0);
        chk("mv_drop", 128'(drop), 128'(1));

        // All four valid for 8 cycles from rr_ptr=1: pairs (1,2),(3,0) alternate.
        for (int r = 0; r < NR; r++) set_req(r, 1'b1, 16 + r, 'hD0 + r);
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("rot%0d_ready", c), 128'(req_ready),
                128'((c % 2 == 0) ? 4'b0110 : 4'b1001));
            for (int r = 0; r < NR; r++) if (req_ready[r]) gcount[r]++;
            step();
            if (c % 2 == 0) chk_wr($sformatf("rot%0d", c), 1'b1, 17, 'hD1, 1'b1, 18, 'hD2);
            else            chk_wr($sformatf("rot%0d", c), 1'b1, 19, 'hD3, 1'b1, 16, 'hD0);
        end
        req_valid = '0;
        for (int r = 0; r < NR; r++) chk($sformatf("rot_cnt%0d", r), 128'(gcount[r]), 128'(4));

        // Clear in IDLE: the grant in that cycle still completes.
        set_req(1, 1'b1, 21, 'hE1);
        clear = 1'b1;
        #1;
        chk("clr_ready", 128'(req_ready), 128'(4'b0010));
        step();
        clear     = 1'b0;
        req_valid = '1;
        chk_wr("clr_grant", 1'b1, 21, 'hE1, 1'b0, 16, 'hD0);
        for (int k = 0; k < 16; k++) begin
            clear = (k >= 2 && k <= 10);
            #1;
            chk($sformatf("sw%0d_busy", k), 128'(busy), 128'(1));
            chk($sformatf("sw%0d_ready", k), 128'(req_ready), 128'(0));
            step();
            if (k < 15) chk_wr($sformatf("sw%0d", k), 1'b1, 2*k + 1, 0, 1'b1, 2*k + 2, 0);
            else        chk_wr($sformatf("sw%0d", k), 1'b1, 31, 0, 1'b0, 30, 0);
            chk($sformatf("sw%0d_busy_after", k), 128'(busy), 128'(k < 15));
        end
        req_valid = '0;
        clear     = 1'b0;
        step();
        chk_wr("sw_done", 1'b0, 31, 0, 1'b0, 30, 0);
        chk("sw_done_busy", 128'(busy), 128'(0));

        // Reset on the 5th sweep cycle aborts the sweep.
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("abort_busy", 128'(busy), 128'(1));
        chk("abort_addr_a", 128'(waddr_a), 128'(7));
        chk("abort_addr_b", 128'(waddr_b), 128'(8));
        rst       = 1'b1;
        req_valid = '1;
        #1;
        chk("abort_rst_ready", 128'(req_ready), 128'(0));
        step();
        rst       = 1'b0;
        req_valid = '0;
        chk_wr("abort_rst", 1'b0, 0, 0, 1'b0, 0, 0);
        chk("abort_rst_busy", 128'(busy), 128'(0));
        step();
        chk("abort_we_a", 128'(we_a), 128'(0));
        chk("abort_we_b", 128'(we_b), 128'(0));
        chk("abort_busy2", 128'(busy), 128'(0));
        set_req(0, 1'b1, 5, 'hF0);
        set_req(3, 1'b1, 6, 'hF3);
        #1;
        chk("post_ready", 128'(req_ready), 128'(4'b1001));
        step();
        req_valid = '0;
        chk_wr("post_wr", 1'b1, 5, 'hF0, 1'b1, 6, 'hF3);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/latch_mem_wr_sched.md
LATCH_MEM_WR_SCHED -- requirements
Module: latch_mem_wr_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters sharing the memory write ports.
REQ-002 Parameter NUM_WORDS, default 32: memory depth; word 0 is hardwired zero.
REQ-003 Parameter ADDR_WIDTH, default 5: word address width.
REQ-004 Parameter DATA_WIDTH, default 128: word width.
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-007 clear_i  in  1  level; starts a zeroing sweep when sampled high in IDLE.
REQ-008 busy_o  out  1  high while the sweep runs.
REQ-009 req_valid_i  in  NUM_REQ  per-requester write-request valid.
REQ-010 req_ready_o  out  NUM_REQ  per-requester grant; combinational.
REQ-011 req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester r at slice r.
REQ-012 req_data_i  in  NUM_REQ*DATA_WIDTH  packed write data, requester r at slice r.
REQ-013 waddr_a_o / wdata_a_o / we_a_o  out  ADDR_WIDTH / DATA_WIDTH / 1  memory write port A, registered.
REQ-014 waddr_b_o / wdata_b_o / we_b_o  out  ADDR_WIDTH / DATA_WIDTH / 1  memory write port B, registered.
REQ-015 drop_o  out  1  one-cycle pulse when an accepted request is discarded (address 0 or address >= NUM_WORDS).

Function
REQ-016 A transfer occurs when req_valid_i[r] and req_ready_o[r] are both high in the same cycle.
REQ-017 The FSM has two states: IDLE and CLEAR.
REQ-018 In IDLE, the block grants at most two requesters per cycle, searching round-robin from rr_ptr upward with wrap at NUM_REQ.
REQ-019 The first eligible requester goes to port A; the second goes to port B.
REQ-020 A candidate whose address equals the port-A address is skipped for port B that cycle, and the search continues.
REQ-021 The skipped requester is not granted and keeps its request pending.
REQ-022 After any grant, rr_ptr advances to (index of last granted requester + 1) mod NUM_REQ; with no grant, rr_ptr is unchanged.
REQ-023 A transferred request with valid address 1..NUM_WORDS-1 appears on its port one cycle later, with we_x_o=1 for exactly one cycle.
REQ-024 A transferred request with address 0 or >= NUM_WORDS is acknowledged but not issued (we_x_o=0), and drop_o=1 the next cycle.
REQ-025 If only one request is issued and it was granted to port B, it shall instead move to port A.
REQ-026 When a port is unused, we_x_o=0 and its addr/data outputs hold their previous values.
REQ-027 clear_i high in IDLE: the FSM enters CLEAR next cycle, and the current cycle's grants still complete.
REQ-028 In CLEAR, all req_ready_o=0, busy_o=1, and clear_i is ignored.
REQ-029 In CLEAR, each cycle issues zero writes: port A gets address n, and port B gets address n+1 if n+1 < NUM_WORDS; n starts at 1 and steps by 2.
REQ-030 The cycle that issues address NUM_WORDS-1 is the last CLEAR cycle, and the FSM returns to IDLE after it.
REQ-031 The sweep takes ceil((NUM_WORDS-1)/2) cycles; for NUM_WORDS=32 that is 16 cycles, with the last cycle using port A only (address 31).
REQ-032 busy_o deasserts in the cycle the FSM is back in IDLE.
REQ-033 Port A and port B never carry the same address with both enables high.

Reset
REQ-034 While rst=1 at a rising edge, the block resets: FSM=IDLE, rr_ptr=0, sweep counter=1.
REQ-035 On reset, all we_*_o=0, waddr_*_o=0, wdata_*_o=0, busy_o=0, drop_o=0.
REQ-036 req_ready_o is 0 during any cycle in which rst=1.
REQ-037 Reset during CLEAR aborts the sweep immediately; no further write is issued after the reset edge.

Verification
REQ-038 Requesters 0,1,2 valid with addresses 3,4,5, rr_ptr=0 -> grants 0 (A) and 1 (B); next cycle we_a/addr 3 and we_b/addr 4, rr_ptr=2.
REQ-039 Requesters 0 and 1 both address 7 -> only requester 0 is granted; requester 1 is granted the next cycle on port A; never two enables with address 7.
REQ-040 Requester 2 alone, address 0 -> ready in the same cycle, no write enable, drop_o=1 one cycle later; the same applies to address 40.
REQ-041 clear_i pulse in IDLE with NUM_WORDS=32 -> 16 busy cycles covering pairs (1,2) ... (29,30), then 31 on A only, all data zero, readies 0 throughout.
REQ-042 rst asserted on the 5th CLEAR cycle -> next cycle busy_o=0, no enables, and a subsequent request is granted normally.
REQ-043 All four requesters held valid with distinct addresses for 8 cycles -> each is granted exactly four times, two grants per cycle, in rotating order.
